// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one instruction memory port between fetch (F, fixed priority) and loader (L, starvation-protected, lockable) with registered 1-cycle responses
module imem_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 32,
  parameter int MAX_WAIT  = 4,
  parameter int LOCK_MAX  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_stall,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_valid,
  output logic              l_err,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_ena,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);
  typedef enum logic {NORM, LOCK} state_t;
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  localparam logic [7:0] LM = 8'(LOCK_MAX);
  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] lock_q, lock_d;
  logic f_valid_q, l_valid_q, l_err_q;
  logic [DATA_W-1:0] f_rdata_q, l_rdata_q;
  logic l_oor;
  assign l_oor = l_addr >= ADDR_W'(MEM_DEPTH);
  always_comb begin
    l_gnt   = ~rst & l_req & (state_q == LOCK | ~f_req | wait_q == MW);
    f_gnt   = ~rst & f_req & (state_q == NORM) & ~l_gnt;
    wait_d  = (l_req & ~l_gnt) ? ((wait_q == MW) ? MW : wait_q + 4'd1) : 4'd0;
    state_d = state_q;
    lock_d  = lock_q;
    if (state_q == NORM) begin
      // a locked burst already counts its first grant; LOCK_MAX==1 never enters LOCK
      state_d = (l_gnt & l_lock & (LOCK_MAX > 1)) ? LOCK : NORM;
      lock_d  = 8'd1;
    end else begin
      // release once this grant brings the burst to LOCK_MAX grants
      state_d = (~l_gnt | ~l_lock | (lock_q + 8'd1 == LM)) ? NORM : LOCK;
      lock_d  = l_gnt ? lock_q + 8'd1 : lock_q;
    end
  end
  assign f_stall  = ~rst & f_req & ~f_gnt;
  assign mem_ena  = f_gnt | (l_gnt & ~l_oor);
  assign mem_wena = l_gnt & ~l_oor & l_we;
  assign mem_addr = f_gnt ? f_addr : l_gnt ? l_addr : '0;
  assign mem_data = mem_wena ? l_wdata : 'z;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NORM;
      wait_q    <= '0;
      lock_q    <= '0;
      f_valid_q <= 1'b0;
      l_valid_q <= 1'b0;
      l_err_q   <= 1'b0;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      lock_q    <= lock_d;
      f_valid_q <= f_gnt;
      l_valid_q <= l_gnt;
      l_err_q   <= l_gnt & l_oor;
      f_rdata_q <= f_gnt ? mem_data : f_rdata_q;
      l_rdata_q <= (l_gnt & ~l_we) ? (l_oor ? '0 : mem_data) : l_rdata_q;
    end
  end
  assign f_valid = f_valid_q;
  assign l_valid = l_valid_q;
  assign l_err   = l_err_q;
  assign f_rdata = f_rdata_q;
  assign l_rdata = l_rdata_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed self-checking bench with a 32-word async-read memory model on the shared pins
module tb_imem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [31:0] f_addr = '0, l_addr = '0, l_wdata = '0;
  logic f_gnt, f_stall, f_valid, l_gnt, l_valid, l_err, mem_ena, mem_wena;
  logic [31:0] f_rdata, l_rdata, mem_addr;
  wire  [31:0] mem_data;
  logic [31:0] mem [32];
  logic load = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;

  imem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_stall(f_stall), .f_valid(f_valid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_valid(l_valid), .l_err(l_err), .l_rdata(l_rdata),
    .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pre(int i);
    return 32'hA000_0000 + 32'(i) * 32'h0001_0011;
  endfunction

  assign mem_data = (mem_ena & ~mem_wena) ? ((mem_addr < 32'd32) ? mem[mem_addr[4:0]] : '0) : 'z;

  always @(posedge clk) begin
    if (load) for (int i = 0; i < 32; i++) mem[i] <= pre(i);
    else if (mem_ena & mem_wena) mem[mem_addr[4:0]] <= mem_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    f_req = 1; l_req = 1; l_we = 1; l_lock = 1; f_addr = 32'd3; l_addr = 32'd2; l_wdata = 32'h1234_5678;
    tick; tick;
    load = 0;
    n_cmp++; if ({f_gnt, l_gnt, f_stall, f_valid, l_valid, l_err, mem_ena, mem_wena} !== 8'b0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=00000000", {f_gnt, l_gnt, f_stall, f_valid, l_valid, l_err, mem_ena, mem_wena}); end
    n_cmp++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_cmp++; if ({f_rdata, l_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got=%h/%h exp=0/0", f_rdata, l_rdata); end
    f_req = 0; l_req = 0; l_we = 0; l_lock = 0;
    rst = 0;
    tick;
  endtask

  task automatic test_fetch_stream;
    for (int i = 0; i < 8; i++) begin
      f_req = 1; f_addr = 32'(i);
      #1;
      n_cmp++; if ({f_gnt, f_stall, mem_ena, mem_wena} !== 4'b1010) begin n_fail++; $display("FAIL fetch_gnt[%0d] got=%b exp=1010", i, {f_gnt, f_stall, mem_ena, mem_wena}); end
      n_cmp++; if (f_valid !== (i > 0)) begin n_fail++; $display("FAIL fetch_valid[%0d] got=%b exp=%b", i, f_valid, i > 0); end
      if (i > 0) begin
        n_cmp++; if (f_rdata !== pre(i - 1)) begin n_fail++; $display("FAIL fetch_rdata[%0d] got=%h exp=%h", i - 1, f_rdata, pre(i - 1)); end
      end
      tick;
    end
    n_cmp++; if ({f_valid, f_rdata} !== {1'b1, pre(7)}) begin n_fail++; $display("FAIL fetch_last got=%b/%h exp=1/%h", f_valid, f_rdata, pre(7)); end
    f_req = 0;
  endtask

  task automatic test_starvation;
    f_req = 1; f_addr = 32'd1;
    l_req = 1; l_we = 1; l_lock = 0; l_addr = 32'd5; l_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if ({f_gnt, l_gnt, f_stall} !== ((c == 4) ? 3'b011 : 3'b100)) begin n_fail++; $display("FAIL starve_gnt[c%0d] got=%b exp=%b", c, {f_gnt, l_gnt, f_stall}, (c == 4) ? 3'b011 : 3'b100); end
      if (c == 4) begin
        n_cmp++; if ({mem_ena, mem_wena, mem_addr, mem_data} !== {2'b11, 32'd5, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL starve_pins got=%b%b/%h/%h exp=11/5/deadbeef", mem_ena, mem_wena, mem_addr, mem_data); end
      end
      tick;
    end
    l_req = 0;
    n_cmp++; if ({l_valid, l_err, f_valid} !== 3'b100) begin n_fail++; $display("FAIL starve_resp got=%b exp=100", {l_valid, l_err, f_valid}); end
    f_addr = 32'd5;
    tick;
    n_cmp++; if ({f_valid, f_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL starve_readback got=%b/%h exp=1/deadbeef", f_valid, f_rdata); end
    f_req = 0;
    tick;
  endtask

  task automatic test_lock_burst;
    int k;
    logic exp_l;
    k = 0;
    f_req = 1; f_addr = 32'd0; l_we = 1;
    for (int c = 0; c < 24; c++) begin
      l_req = (k < 12); l_lock = (k != 11); l_addr = 32'(10 + k); l_wdata = 32'hC0DE_0000 + 32'(k);
      #1;
      exp_l = (c >= 4 && c <= 11) || (c >= 16 && c <= 19);
      n_cmp++; if ({f_gnt, l_gnt} !== {~exp_l, exp_l}) begin n_fail++; $display("FAIL burst_gnt[c%0d] got=%b exp=%b", c, {f_gnt, l_gnt}, {~exp_l, exp_l}); end
      n_cmp++; if (f_gnt & l_gnt) begin n_fail++; $display("FAIL burst_excl[c%0d] got=11 exp=not both", c); end
      if (l_gnt) k++;
      tick;
    end
    n_cmp++; if (k !== 12) begin n_fail++; $display("FAIL burst_count got=%0d exp=12", k); end
    n_cmp++; if ({mem[10], mem[17], mem[21]} !== {32'hC0DE_0000, 32'hC0DE_0007, 32'hC0DE_000B}) begin n_fail++; $display("FAIL burst_mem got=%h/%h/%h exp=c0de0000/c0de0007/c0de000b", mem[10], mem[17], mem[21]); end
    f_req = 0; l_req = 0; l_lock = 0; l_we = 0;
    tick;
  endtask

  task automatic test_out_of_range;
    l_req = 1; l_we = 0; l_addr = 32'd3;
    #1;
    n_cmp++; if ({l_gnt, mem_ena, mem_wena, mem_addr} !== {3'b110, 32'd3}) begin n_fail++; $display("FAIL oor_inrange_pins got=%b/%h exp=110/3", {l_gnt, mem_ena, mem_wena}, mem_addr); end
    tick;
    n_cmp++; if ({l_valid, l_err, l_rdata} !== {2'b10, pre(3)}) begin n_fail++; $display("FAIL oor_inrange_resp got=%b/%h exp=10/%h", {l_valid, l_err}, l_rdata, pre(3)); end
    l_addr = 32'd40;
    #1;
    n_cmp++; if ({l_gnt, mem_ena, mem_wena} !== 3'b100) begin n_fail++; $display("FAIL oor_pins got=%b exp=100", {l_gnt, mem_ena, mem_wena}); end
    tick;
    l_req = 0;
    n_cmp++; if ({l_valid, l_err, l_rdata} !== {2'b11, 32'd0}) begin n_fail++; $display("FAIL oor_resp got=%b/%h exp=11/0", {l_valid, l_err}, l_rdata); end
    tick;
    n_cmp++; if ({l_valid, l_err} !== 2'b00) begin n_fail++; $display("FAIL oor_idle got=%b exp=00", {l_valid, l_err}); end
  endtask

  task automatic test_reset_mid_burst;
    f_req = 0; l_req = 1; l_we = 1; l_lock = 1; l_addr = 32'd30; l_wdata = 32'hBAD0_BAD0;
    tick;
    l_addr = 32'd31; l_wdata = 32'hBAD1_BAD1; f_req = 1;
    #1;
    n_cmp++; if ({f_gnt, l_gnt, l_valid} !== 3'b011) begin n_fail++; $display("FAIL midrst_lock got=%b exp=011", {f_gnt, l_gnt, l_valid}); end
    rst = 1;
    #1;
    n_cmp++; if ({f_gnt, l_gnt, mem_ena, mem_wena, l_valid, f_valid} !== 6'b0) begin n_fail++; $display("FAIL midrst_clear got=%b exp=000000", {f_gnt, l_gnt, mem_ena, mem_wena, l_valid, f_valid}); end
    tick; tick;
    n_cmp++; if ({mem[30], mem[31]} !== {32'hBAD0_BAD0, pre(31)}) begin n_fail++; $display("FAIL midrst_mem got=%h/%h exp=bad0bad0/%h", mem[30], mem[31], pre(31)); end
    l_req = 0; f_req = 0;
    rst = 0;
    #1;
    l_req = 1; f_req = 1; l_lock = 0;
    #1;
    n_cmp++; if ({f_gnt, l_gnt} !== 2'b10) begin n_fail++; $display("FAIL midrst_norm got=%b exp=10", {f_gnt, l_gnt}); end
    tick;
    l_req = 0; f_req = 0; l_we = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_fetch_stream;
    test_starvation;
    test_lock_burst;
    test_out_of_range;
    test_reset_mid_burst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
